hamming_secded_codec: RTL and testbench

- Parametrised, pipelined SECDED Hamming codec; one instance either encodes or decodes, selected per transaction.
- For DATA_W=32 it produces the team's standard 39-bit codeword, plus decode with single-error correction and double-error detection.
- Valid/ready streaming on both sides; throughput 1 word/cycle; saturating error statistics.
- Sits between datapath producers and storage/link blocks that need protected words.

---
 rtl/hamming_pkg.sv | 36 +++
 rtl/hamming_syndrome.sv | 24 ++
 rtl/hamming_secded_codec.sv | 156 +++++++++++++++
 tb/tb_hamming_secded_codec.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming codec: mode encodings,
// parity-width derivation and the data-bit to codeword-position map.
package hamming_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1)
            r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position of data bit idx: the idx-th non-power-of-two
    // position counting upward from 1.
    function automatic int data_pos(input int idx);
        int pos;
        int n;
        pos = 0;
        n = -1;
        while (n < idx) begin
            pos++;
            if (!is_pow2(pos))
                n++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator.
// Ports: word (CODE_W codeword) -> syndrome (PAR_W), overall_bad (XOR of all bits).
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int PAR_W = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic [CODE_W-1:0] word,
    output logic [PAR_W-1:0]  syndrome,
    output logic              overall_bad
);

    always_comb begin
        syndrome = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (word[p])
                syndrome = syndrome ^ PAR_W'(p);
        end
        overall_bad = ^word;
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined SECDED encoder/decoder with valid/ready streaming
// and saturating corrected/uncorrectable counters.
// Ports: clk, rst (async high); in_valid/in_ready/in_mode/in_data;
// out_valid/out_ready/out_mode/out_data/out_syndrome/out_single_err/
// out_double_err; err_clr, corr_cnt, uncorr_cnt.
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W = 16,
    localparam int PAR_W = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_single_err,
    output logic              out_double_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic [CODE_W-1:0] enc_word;
    logic [CODE_W-1:0] syn_word;
    logic [PAR_W-1:0]  syn_in;
    logic              bad_in;

    logic              s1_valid;
    logic              s1_mode;
    logic [CODE_W-1:0] s1_word;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_bad;

    logic              s2_load;
    logic              in_fire;
    logic              out_fire;

    logic [CODE_W-1:0] res_data;
    logic [PAR_W-1:0]  res_syn;
    logic              res_single;
    logic              res_double;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] fixed;

    // Data scattered into its positions with every parity field zero,
    // so the syndrome of this word is exactly the parity vector.
    always_comb begin
        enc_word = '0;
        for (int i = 0; i < DATA_W; i++)
            enc_word[data_pos(i)] = in_data[i];
    end

    assign syn_word = (in_mode == MODE_DEC) ? in_data : enc_word;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .word        (syn_word),
        .syndrome    (syn_in),
        .overall_bad (bad_in)
    );

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_ENC;
            s1_word  <= '0;
            s1_syn   <= '0;
            s1_bad   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_mode  <= in_mode;
            s1_word  <= syn_word;
            s1_syn   <= syn_in;
            s1_bad   <= bad_in;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        res_data   = '0;
        res_syn    = '0;
        res_single = 1'b0;
        res_double = 1'b0;
        code       = s1_word;
        fixed      = s1_word;
        if (s1_mode == MODE_ENC) begin
            for (int k = 0; k < PAR_W; k++)
                code[1 << k] = s1_syn[k];
            code[0]  = ^code[CODE_W-1:1];
            res_data = code;
        end else begin
            res_syn = s1_syn;
            if (s1_syn == '0) begin
                // Only bit 0 can be wrong; data is intact.
                res_single = s1_bad;
            end else if (!s1_bad || int'(s1_syn) > CODE_W - 1) begin
                res_double = 1'b1;
            end else begin
                res_single = 1'b1;
                fixed = s1_word ^ (CODE_W'(1) << s1_syn);
            end
            for (int i = 0; i < DATA_W; i++)
                res_data[i] = fixed[data_pos(i)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_mode       <= MODE_ENC;
            out_data       <= '0;
            out_syndrome   <= '0;
            out_single_err <= 1'b0;
            out_double_err <= 1'b0;
        end else if (s2_load) begin
            out_valid      <= 1'b1;
            out_mode       <= s1_mode;
            out_data       <= res_data;
            out_syndrome   <= res_syn;
            out_single_err <= res_single;
            out_double_err <= res_double;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (err_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_fire && out_mode == MODE_DEC) begin
            if (out_single_err && corr_cnt != '1)
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_double_err && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed self-checking bench for hamming_secded_codec (DATA_W=32),
// plus a second instance with 2-bit counters for saturation/clear.
module tb_hamming_secded_codec;

    localparam logic [38:0] CW_A   = 39'h65BF8C8F4F;
    localparam logic [38:0] CW_A5  = 39'h65BF8C8F6F;
    localparam logic [38:0] CW_A0  = 39'h65BF8C8F4E;
    localparam logic [38:0] CW_DBL = 39'h65BF8C8B47;
    localparam logic [38:0] CW_HI  = 39'h0180000001;
    localparam logic [38:0] D_A    = 39'h00CAFE3475;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode;
    logic [38:0] in_data;
    logic        out_valid, out_ready, out_mode;
    logic [38:0] out_data;
    logic [5:0]  out_syndrome;
    logic        out_single_err, out_double_err, err_clr;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        in_valid_b, in_ready_b, in_mode_b;
    logic [38:0] in_data_b;
    logic        out_valid_b, out_ready_b, out_mode_b;
    logic [38:0] out_data_b;
    logic [5:0]  out_syndrome_b;
    logic        out_single_err_b, out_double_err_b, err_clr_b;
    logic [1:0]  corr_cnt_b, uncorr_cnt_b;

    int errors = 0;
    int checks = 0;

    logic        v_mode[8];
    logic [38:0] v_in[8];
    logic [38:0] v_exp[8];
    logic [5:0]  v_syn[8];
    logic        v_sg[8];
    logic        v_db[8];

    always #5 clk = ~clk;

    hamming_secded_codec #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_single_err(out_single_err), .out_double_err(out_double_err),
        .err_clr(err_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hamming_secded_codec #(.DATA_W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_mode(in_mode_b),
        .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_mode(out_mode_b), .out_data(out_data_b),
        .out_syndrome(out_syndrome_b),
        .out_single_err(out_single_err_b), .out_double_err(out_double_err_b),
        .err_clr(err_clr_b), .corr_cnt(corr_cnt_b), .uncorr_cnt(uncorr_cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_word(input logic mode, input logic [38:0] data,
                            input logic [38:0] ed, input logic [5:0] es,
                            input logic esg, input logic edb,
                            input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_data   = data;
        out_ready = 1'b1;
        chk({tag, "/in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        chk({tag, "/lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "/valid"}, out_valid, 1);
        chk({tag, "/mode"}, out_mode, mode);
        chk({tag, "/data"}, out_data, ed);
        chk({tag, "/syn"}, out_syndrome, es);
        chk({tag, "/single"}, out_single_err, esg);
        chk({tag, "/double"}, out_double_err, edb);
    endtask

    task automatic run_stream(input bit toggle, input string tag);
        int sent;
        int recv;
        int cyc;
        bit stalled;
        bit saw_block;
        logic [38:0] hd;
        logic [5:0]  hs;
        logic        hm, hsg, hdb;
        sent = 0;
        recv = 0;
        stalled = 1'b0;
        saw_block = 1'b0;
        hd = '0; hs = '0; hm = 1'b0; hsg = 1'b0; hdb = 1'b0;
        for (cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_mode = v_mode[sent];
                in_data = v_in[sent];
            end
            #1;
            if (stalled) begin
                chk($sformatf("%s/hold_valid%0d", tag, cyc), out_valid, 1);
                chk($sformatf("%s/hold_data%0d", tag, cyc), out_data, hd);
                chk($sformatf("%s/hold_syn%0d", tag, cyc), out_syndrome, hs);
                chk($sformatf("%s/hold_mode%0d", tag, cyc), out_mode, hm);
                chk($sformatf("%s/hold_flags%0d", tag, cyc),
                    {out_single_err, out_double_err}, {hsg, hdb});
            end
            if (out_ready)
                chk($sformatf("%s/in_ready%0d", tag, cyc), in_ready, 1);
            if (!in_ready)
                saw_block = 1'b1;
            if (out_valid && out_ready) begin
                chk($sformatf("%s/mode%0d", tag, recv), out_mode, v_mode[recv]);
                chk($sformatf("%s/data%0d", tag, recv), out_data, v_exp[recv]);
                chk($sformatf("%s/syn%0d", tag, recv), out_syndrome, v_syn[recv]);
                chk($sformatf("%s/flags%0d", tag, recv),
                    {out_single_err, out_double_err}, {v_sg[recv], v_db[recv]});
                recv++;
            end
            stalled = out_valid && !out_ready;
            hd = out_data; hs = out_syndrome; hm = out_mode;
            hsg = out_single_err; hdb = out_double_err;
            if (in_valid && in_ready)
                sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "/received"}, recv, 8);
        if (toggle)
            chk({tag, "/in_ready_fell"}, saw_block, 1);
        else
            chk({tag, "/cycles"}, cyc, 10);
    endtask

    initial begin
        v_mode[0] = 1'b0; v_in[0] = 39'h00CAFE3475; v_exp[0] = CW_A;
        v_mode[1] = 1'b1; v_in[1] = CW_A;           v_exp[1] = D_A;
        v_mode[2] = 1'b0; v_in[2] = 39'h0000000001; v_exp[2] = 39'h000000000F;
        v_mode[3] = 1'b1; v_in[3] = CW_A5;          v_exp[3] = D_A;
        v_mode[4] = 1'b0; v_in[4] = 39'h0080000000; v_exp[4] = 39'h4100000014;
        v_mode[5] = 1'b1; v_in[5] = CW_DBL;         v_exp[5] = 39'h00CAFE3454;
        v_mode[6] = 1'b0; v_in[6] = '0;             v_exp[6] = '0;
        v_mode[7] = 1'b1; v_in[7] = 39'h000000000F; v_exp[7] = 39'h0000000001;
        for (int i = 0; i < 8; i++) begin
            v_syn[i] = '0; v_sg[i] = 1'b0; v_db[i] = 1'b0;
        end
        v_syn[3] = 6'd5; v_sg[3] = 1'b1;
        v_syn[5] = 6'd9; v_db[5] = 1'b1;

        rst = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        in_valid_b = 1'b0; in_mode_b = 1'b0; in_data_b = '0;
        out_ready_b = 1'b1; err_clr_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/in_ready", in_ready, 1);
        chk("rst/out_data", out_data, 0);
        chk("rst/out_misc", {out_mode, out_syndrome, out_single_err,
            out_double_err}, 0);
        chk("rst/counters", {corr_cnt, uncorr_cnt}, 0);
        rst = 1'b0;

        run_word(1'b0, 39'h00CAFE3475, CW_A, 6'd0, 1'b0, 1'b0, "enc_A");
        run_word(1'b1, CW_A, D_A, 6'd0, 1'b0, 1'b0, "dec_A");
        run_word(1'b0, '0, '0, 6'd0, 1'b0, 1'b0, "enc_zero");
        run_word(1'b0, 39'h7F00000001, 39'h000000000F, 6'd0, 1'b0, 1'b0,
                 "enc_upper_ignored");
        run_word(1'b0, 39'h0080000000, 39'h4100000014, 6'd0, 1'b0, 1'b0,
                 "enc_msb");
        run_word(1'b1, CW_A5, D_A, 6'd5, 1'b1, 1'b0, "dec_flip5");
        @(negedge clk);
        chk("cnt/corr_after_flip5", corr_cnt, 1);
        run_word(1'b1, CW_A0, D_A, 6'd0, 1'b1, 1'b0, "dec_flip0");
        @(negedge clk);
        chk("cnt/corr_after_flip0", corr_cnt, 2);
        run_word(1'b1, CW_DBL, 39'h00CAFE3454, 6'd9, 1'b0, 1'b1, "dec_dbl");
        @(negedge clk);
        chk("cnt/uncorr_after_dbl", uncorr_cnt, 1);
        run_word(1'b1, CW_HI, 39'h0002000000, 6'h3F, 1'b0, 1'b1,
                 "dec_syn_oob");
        @(negedge clk);
        chk("cnt/uncorr_after_oob", uncorr_cnt, 2);
        chk("cnt/corr_unchanged", corr_cnt, 2);

        run_stream(1'b1, "bp");
        @(negedge clk);
        chk("bp/corr", corr_cnt, 3);
        chk("bp/uncorr", uncorr_cnt, 3);
        run_stream(1'b0, "full");
        @(negedge clk);
        chk("full/corr", corr_cnt, 4);
        chk("full/uncorr", uncorr_cnt, 4);

        @(negedge clk);
        in_valid_b = 1'b1; in_mode_b = 1'b1; in_data_b = CW_A5;
        repeat (5) @(negedge clk);
        in_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat/corr", corr_cnt_b, 3);
        chk("sat/uncorr", uncorr_cnt_b, 0);
        err_clr_b = 1'b1;
        @(negedge clk);
        err_clr_b = 1'b0;
        chk("clr/alone", corr_cnt_b, 0);
        in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        @(negedge clk);
        chk("clr/out_valid", out_valid_b, 1);
        err_clr_b = 1'b1;
        @(negedge clk);
        err_clr_b = 1'b0;
        chk("clr/coincident", corr_cnt_b, 0);
        in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr/count_resumes", corr_cnt_b, 1);

        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 39'h00CAFE3475;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst/pre_valid", out_valid, 1);
        chk("midrst/pre_in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst/out_valid", out_valid, 0);
        chk("midrst/in_ready", in_ready, 1);
        chk("midrst/out_data", out_data, 0);
        chk("midrst/counters", {corr_cnt, uncorr_cnt}, 0);
        chk("midrst/counters_b", {corr_cnt_b, uncorr_cnt_b}, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst/no_stale%0d", i), out_valid, 0);
        end
        run_word(1'b1, CW_A, D_A, 6'd0, 1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
